ahbl_dma_master: RTL and testbench

//  Single-channel AHB-Lite initiator: copies cmd_len 32-bit words from cmd_src to cmd_dst.

---
 rtl/ahbl_dma_master_if.sv | 49 ++++
 rtl/ahbl_dma_master.sv | 160 ++++++++++++++++
 tb/tb_ahbl_dma_master.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahbl_dma_master_if.sv
// Command port and AHB-Lite initiator signals of the single-channel DMA master.
// The master modport is the DMA side; the slave modport is the bus/client side.
interface ahbl_dma_master_if #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32,
  parameter int W_LEN  = 16
) ();

  // Command port
  logic              cmd_valid;
  logic              cmd_ready;
  logic [W_ADDR-1:0] cmd_src;
  logic [W_ADDR-1:0] cmd_dst;
  logic [W_LEN-1:0]  cmd_len;

  // Status
  logic              busy;
  logic              done;
  logic              err;
  logic [W_ADDR-1:0] err_addr;

  // AHB-Lite initiator
  logic [W_ADDR-1:0] haddr;
  logic              hwrite;
  logic [1:0]        htrans;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [3:0]        hprot;
  logic              hmastlock;
  logic [W_DATA-1:0] hwdata;
  logic              hready;
  logic              hresp;
  logic [W_DATA-1:0] hrdata;

  modport master (
    input  cmd_valid, cmd_src, cmd_dst, cmd_len,
    input  hready, hresp, hrdata,
    output cmd_ready, busy, done, err, err_addr,
    output haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hwdata
  );

  modport slave (
    output cmd_valid, cmd_src, cmd_dst, cmd_len,
    output hready, hresp, hrdata,
    input  cmd_ready, busy, done, err, err_addr,
    input  haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hwdata
  );

endinterface

// File: rtl/ahbl_dma_master.sv
// Single-channel AHB-Lite DMA initiator.
// Copies cmd_len words from cmd_src to cmd_dst, one SINGLE read then one SINGLE
// write per word. Any error response aborts the command and reports the address.
module ahbl_dma_master #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32,
  parameter int W_LEN  = 16
) (
  input  logic               clk,
  input  logic               rst,
  ahbl_dma_master_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RA,
    S_RD,
    S_WA,
    S_WD
  } state_t;

  localparam logic [1:0]        HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]        HTRANS_NONSEQ = 2'b10;
  localparam logic [W_ADDR-1:0] ALIGN_MASK    = {{(W_ADDR-2){1'b1}}, 2'b00};
  localparam logic [W_ADDR-1:0] WORD_STEP     = W_ADDR'(4);

  state_t            state_q, state_d;
  logic [W_ADDR-1:0] src_q, src_d;
  logic [W_ADDR-1:0] dst_q, dst_d;
  logic [W_LEN-1:0]  len_q, len_d;
  logic [W_DATA-1:0] buf_q, buf_d;
  logic [W_ADDR-1:0] err_addr_q, err_addr_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // State and datapath registers; synchronous reset drops any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      buf_q      <= '0;
      err_addr_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      buf_q      <= buf_d;
      err_addr_q <= err_addr_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next state: accept commands in IDLE, step through read/write phases, abort on hresp.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    buf_d      = buf_q;
    err_addr_d = err_addr_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          src_d = bus.cmd_src & ALIGN_MASK;
          dst_d = bus.cmd_dst & ALIGN_MASK;
          len_d = bus.cmd_len;
          if (bus.cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_RA;
          end
        end
      end
      S_RA: begin
        if (bus.hready) begin
          state_d = S_RD;
        end
      end
      S_RD: begin
        if (bus.hresp) begin
          err_d      = 1'b1;
          err_addr_d = src_q;
          state_d    = S_IDLE;
        end else if (bus.hready) begin
          buf_d   = bus.hrdata;
          state_d = S_WA;
        end
      end
      S_WA: begin
        if (bus.hready) begin
          state_d = S_WD;
        end
      end
      S_WD: begin
        if (bus.hresp) begin
          err_d      = 1'b1;
          err_addr_d = dst_q;
          state_d    = S_IDLE;
        end else if (bus.hready) begin
          src_d = src_q + WORD_STEP;
          dst_d = dst_q + WORD_STEP;
          len_d = len_q - W_LEN'(1);
          if (len_q == W_LEN'(1)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_RA;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bus outputs: address phase only in RA/WA, write data only in WD, otherwise quiet.
  always_comb begin
    bus.htrans = HTRANS_IDLE;
    bus.haddr  = '0;
    bus.hwrite = 1'b0;
    bus.hwdata = '0;
    unique case (state_q)
      S_RA: begin
        bus.htrans = HTRANS_NONSEQ;
        bus.haddr  = src_q;
      end
      S_WA: begin
        bus.htrans = HTRANS_NONSEQ;
        bus.hwrite = 1'b1;
        bus.haddr  = dst_q;
      end
      S_WD: begin
        bus.hwdata = buf_q;
      end
      default: begin
      end
    endcase
  end

  assign bus.hsize     = 3'b010;
  assign bus.hburst    = 3'b000;
  assign bus.hprot     = 4'b0011;
  assign bus.hmastlock = 1'b0;

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.err_addr  = err_addr_q;

endmodule

// File: tb/tb_ahbl_dma_master.sv
// Testbench for ahbl_dma_master: a behavioural AHB-Lite memory slave with
// configurable wait states and error injection, a table of copy commands,
// and hand-written sequences for stalls, error abort and reset mid-transfer.
`timescale 1ns/1ps
module tb_ahbl_dma_master;

  localparam int W_ADDR = 32;
  localparam int W_DATA = 32;
  localparam int W_LEN  = 16;
  localparam logic [1:0] NONSEQ = 2'b10;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ahbl_dma_master_if #(.W_ADDR(W_ADDR), .W_DATA(W_DATA), .W_LEN(W_LEN)) bus ();

  ahbl_dma_master #(.W_ADDR(W_ADDR), .W_DATA(W_DATA), .W_LEN(W_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total_cnt = 0;
  int bad_cnt   = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
  } xfer_t;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    int          exp_cyc;
  } vec_t;

  xfer_t xfer_log[$];
  logic [31:0] mem [logic [31:0]];

  // Slave model state
  logic        dp_valid = 1'b0;
  logic        dp_write = 1'b0;
  logic [31:0] dp_addr  = '0;
  int          dp_wait  = 0;
  logic        dp_err   = 1'b0;
  logic        err_stage = 1'b0;
  int          rd_wait = 0;
  int          wr_wait = 0;
  int          ra_stall_left = 0;
  logic        err_en = 1'b0;
  logic [31:0] err_wr_addr = '0;
  logic        stall_prev = 1'b0;
  logic        sv_wdata_chk = 1'b0;
  logic [31:0] sv_haddr, sv_hwdata;
  logic [1:0]  sv_htrans;
  logic        sv_hwrite;
  logic        drv_ready, drv_resp;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_cnt++;
    if (actual !== expected) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] pattern(input logic [31:0] a);
    return a ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : pattern(a);
  endfunction

  // AHB-Lite slave: decides hready/hresp for the coming edge and tracks the data phase.
  always @(negedge clk) begin
    if (rst) begin
      dp_valid   = 1'b0;
      err_stage  = 1'b0;
      stall_prev = 1'b0;
      bus.hready = 1'b1;
      bus.hresp  = 1'b0;
    end else begin
      if (stall_prev) begin
        checkOutput("stable_haddr", bus.haddr, sv_haddr);
        checkOutput("stable_htrans", 32'(bus.htrans), 32'(sv_htrans));
        checkOutput("stable_hwrite", 32'(bus.hwrite), 32'(sv_hwrite));
        if (sv_wdata_chk) checkOutput("stable_hwdata", bus.hwdata, sv_hwdata);
      end
      drv_ready  = 1'b1;
      drv_resp   = 1'b0;
      stall_prev = 1'b0;
      if (dp_valid) begin
        if (dp_wait > 0) begin
          drv_ready  = 1'b0;
          dp_wait--;
          stall_prev = 1'b1;
        end else if (dp_err && !err_stage) begin
          drv_ready = 1'b0;
          drv_resp  = 1'b1;
          err_stage = 1'b1;
        end else if (dp_err) begin
          drv_resp  = 1'b1;
          err_stage = 1'b0;
        end else if (dp_write) begin
          mem[dp_addr] = bus.hwdata;
        end else begin
          bus.hrdata = mem_read(dp_addr);
        end
      end else if (bus.htrans == NONSEQ && !bus.hwrite && ra_stall_left > 0) begin
        drv_ready  = 1'b0;
        ra_stall_left--;
        stall_prev = 1'b1;
      end
      if (stall_prev) begin
        sv_haddr     = bus.haddr;
        sv_htrans    = bus.htrans;
        sv_hwrite    = bus.hwrite;
        sv_hwdata    = bus.hwdata;
        sv_wdata_chk = dp_valid && dp_write;
      end
      if (drv_ready) begin
        dp_valid  = (bus.htrans == NONSEQ);
        dp_write  = bus.hwrite;
        dp_addr   = bus.haddr;
        dp_wait   = bus.hwrite ? wr_wait : rd_wait;
        dp_err    = err_en && bus.hwrite && (bus.haddr == err_wr_addr);
        err_stage = 1'b0;
        if (dp_valid) xfer_log.push_back('{bus.hwrite, bus.haddr});
      end
      bus.hready = drv_ready;
      bus.hresp  = drv_resp;
    end
  end

  // Present one command for a single cycle; returns just after the accepting edge.
  task automatic applyStimulus(input string tag, input logic [31:0] src, input logic [31:0] dst,
                               input logic [15:0] len);
    xfer_log.delete();
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_src   = src;
    bus.cmd_dst   = dst;
    bus.cmd_len   = len;
    checkOutput({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_src   = '0;
    bus.cmd_dst   = '0;
    bus.cmd_len   = '0;
  endtask

  task automatic waitDone(input string tag, input int bound, output int cyc, output logic got_done,
                          output logic got_err, output logic busy_seen);
    got_done  = 1'b0;
    got_err   = 1'b0;
    busy_seen = 1'b0;
    cyc       = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (bus.busy) busy_seen = 1'b1;
      if (bus.done || bus.err) begin
        got_done = bus.done;
        got_err  = bus.err;
        cyc      = i;
        break;
      end
    end
    checkOutput({tag, "_completion_seen"}, 32'(got_done | got_err), 32'd1);
  endtask

  // Wait for a clean completion and compare timing, bus address order and copied data.
  task automatic checkCopy(input string tag, input logic [31:0] src, input logic [31:0] dst,
                           input logic [15:0] len, input int exp_cyc);
    int          cyc;
    logic        got_done, got_err, busy_seen;
    logic [31:0] s_a, d_a;
    waitDone(tag, 200, cyc, got_done, got_err, busy_seen);
    checkOutput({tag, "_done"}, 32'(got_done), 32'd1);
    checkOutput({tag, "_no_err"}, 32'(got_err), 32'd0);
    checkOutput({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    checkOutput({tag, "_busy_seen"}, 32'(busy_seen), 32'(len != 16'd0));
    @(negedge clk);
    checkOutput({tag, "_done_width"}, 32'(bus.done), 32'd0);
    checkOutput({tag, "_cmd_ready_after"}, 32'(bus.cmd_ready), 32'd1);
    checkOutput({tag, "_log_size"}, 32'(xfer_log.size()), 32'(2 * int'(len)));
    if (xfer_log.size() == 2 * int'(len)) begin
      for (int i = 0; i < int'(len); i++) begin
        s_a = (src & 32'hFFFF_FFFC) + 32'(4 * i);
        d_a = (dst & 32'hFFFF_FFFC) + 32'(4 * i);
        checkOutput($sformatf("%s_rd%0d_addr", tag, i), xfer_log[2*i].addr, s_a);
        checkOutput($sformatf("%s_rd%0d_dir", tag, i), 32'(xfer_log[2*i].wr), 32'd0);
        checkOutput($sformatf("%s_wr%0d_addr", tag, i), xfer_log[2*i+1].addr, d_a);
        checkOutput($sformatf("%s_wr%0d_dir", tag, i), 32'(xfer_log[2*i+1].wr), 32'd1);
        checkOutput($sformatf("%s_data%0d", tag, i), mem_read(d_a), pattern(s_a));
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got time limit expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        vecs[5];
    int          cyc;
    logic        got_done, got_err, busy_seen, found, prev_wa;

    vecs[0] = '{32'h4200_0000, 32'h4200_0100, 16'd3, 12};
    vecs[1] = '{32'h4200_0200, 32'h4200_0300, 16'd0, 0};
    vecs[2] = '{32'hFFFF_FFF8, 32'h4100_0000, 16'd3, 12};
    vecs[3] = '{32'h4200_0403, 32'h4200_0502, 16'd2, 8};
    vecs[4] = '{32'h4400_0010, 32'h4400_0020, 16'd1, 4};

    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_src   = '0;
    bus.cmd_dst   = '0;
    bus.cmd_len   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    @(negedge clk);
    checkOutput("rst_htrans", 32'(bus.htrans), 32'd0);
    checkOutput("rst_haddr", bus.haddr, 32'd0);
    checkOutput("rst_hwrite", 32'(bus.hwrite), 32'd0);
    checkOutput("rst_hwdata", bus.hwdata, 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_err", 32'(bus.err), 32'd0);
    checkOutput("rst_err_addr", bus.err_addr, 32'd0);
    checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    checkOutput("rst_hsize", 32'(bus.hsize), 32'd2);
    checkOutput("rst_hburst", 32'(bus.hburst), 32'd0);
    checkOutput("rst_hprot", 32'(bus.hprot), 32'd3);
    checkOutput("rst_hmastlock", 32'(bus.hmastlock), 32'd0);

    // Zero-wait copies, zero length, address wrap and unaligned command addresses
    for (int v = 0; v < 5; v++) begin
      applyStimulus($sformatf("vec%0d", v), vecs[v].src, vecs[v].dst, vecs[v].len);
      checkCopy($sformatf("vec%0d", v), vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].exp_cyc);
    end

    // Three stall cycles in the read address phase and in the write data phase
    ra_stall_left = 3;
    wr_wait       = 3;
    applyStimulus("wait", 32'h4500_0000, 32'h4500_0100, 16'd1);
    checkCopy("wait", 32'h4500_0000, 32'h4500_0100, 16'd1, 10);
    ra_stall_left = 0;
    wr_wait       = 0;

    // Error response on the second write aborts the command
    err_en      = 1'b1;
    err_wr_addr = 32'h4900_0008;
    applyStimulus("err", 32'h4300_0000, 32'h4900_0004, 16'd3);
    waitDone("err", 200, cyc, got_done, got_err, busy_seen);
    checkOutput("err_pulse", 32'(got_err), 32'd1);
    checkOutput("err_no_done", 32'(got_done), 32'd0);
    checkOutput("err_cycles", 32'(cyc), 32'd8);
    checkOutput("err_addr", bus.err_addr, 32'h4900_0008);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("err_quiet%0d", i), 32'({bus.done, bus.err}), 32'd0);
    end
    checkOutput("err_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    checkOutput("err_busy", 32'(bus.busy), 32'd0);
    checkOutput("err_log_size", 32'(xfer_log.size()), 32'd4);
    if (xfer_log.size() == 4) begin
      checkOutput("err_rd2_addr", xfer_log[2].addr, 32'h4300_0004);
      checkOutput("err_wr2_addr", xfer_log[3].addr, 32'h4900_0008);
      checkOutput("err_wr2_dir", 32'(xfer_log[3].wr), 32'd1);
    end
    err_en = 1'b0;

    // err_addr holds across a following successful command
    applyStimulus("hold", 32'h4600_0000, 32'h4600_0100, 16'd1);
    checkCopy("hold", 32'h4600_0000, 32'h4600_0100, 16'd1, 4);
    checkOutput("hold_err_addr", bus.err_addr, 32'h4900_0008);

    // Reset asserted while the first write data phase is stalled
    wr_wait = 2;
    applyStimulus("rstwd", 32'h4700_0000, 32'h4700_0100, 16'd2);
    found   = 1'b0;
    prev_wa = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (prev_wa) begin
        found = 1'b1;
        break;
      end
      prev_wa = (bus.htrans == NONSEQ) && bus.hwrite;
      @(posedge clk); #1;
    end
    checkOutput("rstwd_reached_wd", 32'(found), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstwd_htrans", 32'(bus.htrans), 32'd0);
    checkOutput("rstwd_busy", 32'(bus.busy), 32'd0);
    checkOutput("rstwd_done", 32'(bus.done), 32'd0);
    checkOutput("rstwd_err", 32'(bus.err), 32'd0);
    checkOutput("rstwd_haddr", bus.haddr, 32'd0);
    checkOutput("rstwd_hwdata", bus.hwdata, 32'd0);
    checkOutput("rstwd_err_addr", bus.err_addr, 32'd0);
    checkOutput("rstwd_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("rstwd_quiet%0d", i), 32'({bus.done, bus.err, bus.busy}), 32'd0);
    end
    wr_wait = 0;
    applyStimulus("after", 32'h4800_0000, 32'h4800_0100, 16'd2);
    checkCopy("after", 32'h4800_0000, 32'h4800_0100, 16'd2, 8);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
